// File: rtl/knn_pkg.sv
// Shared definitions for the KNN distance datapath: metric mode encodings,
// engine FSM states, class-tag width default and a ceil-log2 helper.
package knn_pkg;

  localparam logic MODE_SQ  = 1'b0;
  localparam logic MODE_ABS = 1'b1;

  localparam int TYPE_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/knn_lane_metric.sv
// One lane of the distance datapath, purely combinational.
// o_diff is the signed difference a - b widened to W+1 bits (feeds the S1 register).
// o_metric is the per-lane term computed from the registered difference i_diff:
// |diff| zero-extended, or diff*diff, both as 2W-bit unsigned values.
module knn_lane_metric
  import knn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [W:0]     i_diff,
  input  logic           i_mode,
  output logic [W:0]     o_diff,
  output logic [2*W-1:0] o_metric
);

  logic [W:0]     w_abs;
  logic [2*W-1:0] w_sq;

  assign o_diff = {i_a[W-1], i_a} - {i_b[W-1], i_b};

  // |diff| never exceeds 2^W-1, so squaring the magnitude fits in 2W bits exactly.
  assign w_abs    = i_diff[W] ? (~i_diff + 1'b1) : i_diff;
  assign w_sq     = (2*W)'(w_abs) * (2*W)'(w_abs);
  assign o_metric = (i_mode == MODE_ABS) ? (2*W)'(w_abs) : w_sq;

endmodule

// File: rtl/knn_distance_engine.sv
// Streaming multi-lane distance engine: takes a query/training vector pair as
// LANES-wide beats, accumulates squared-Euclidean or Manhattan distance through
// a diff -> metric -> lane-sum pipeline, and hands the result plus class tag
// to the k-best sorter with a valid/ready handshake.
module knn_distance_engine
  import knn_pkg::*;
#(
  parameter int W      = 8,
  parameter int N_ELEM = 64,
  parameter int LANES  = 4,
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W*LANES-1:0]         in_a,
  input  logic [W*LANES-1:0]         in_b,
  input  logic [TYPE_W-1:0]          in_type,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*W+clog2(N_ELEM):0] out_dist,
  output logic [TYPE_W-1:0]          out_type,
  output logic                       busy
);

  localparam int ACC_W = 2*W + clog2(N_ELEM) + 1;
  localparam int BEATS = (N_ELEM + LANES - 1) / LANES;
  localparam int BCW   = (BEATS > 1) ? clog2(BEATS) : 1;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_mode;
  logic [ACC_W-1:0]  r_out_dist;
  logic [TYPE_W-1:0] r_out_type;
  logic [TYPE_W-1:0] r_type;
  logic [BCW-1:0]    r_beat;
  logic [ACC_W-1:0]  r_acc;

  logic              r_s1_valid;
  logic              r_s2_valid;
  logic              r_s3_valid;
  logic [W:0]        r_s1_diff   [LANES];
  logic [2*W-1:0]    r_s2_metric [LANES];
  logic [ACC_W-1:0]  r_s3_sum;

  logic [W:0]        w_diff   [LANES];
  logic [2*W-1:0]    w_metric [LANES];
  logic [LANES-1:0]  w_live;
  logic [ACC_W-1:0]  w_tree;
  logic              w_accept;
  logic              w_start_take;
  logic              w_pipe_empty;

  assign w_accept     = in_valid & r_in_ready;
  assign w_pipe_empty = ~(r_s1_valid | r_s2_valid | r_s3_valid);
  // A new vector begins either from idle or in the same cycle the previous result is taken.
  assign w_start_take = start & ((r_state == ST_IDLE) |
                                 ((r_state == ST_OUT) & r_out_valid & out_ready));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    knn_lane_metric #(
      .W(W)
    ) u_metric (
      .i_a      (in_a[(g+1)*W-1 -: W]),
      .i_b      (in_b[(g+1)*W-1 -: W]),
      .i_diff   (r_s1_diff[g]),
      .i_mode   (r_mode),
      .o_diff   (w_diff[g]),
      .o_metric (w_metric[g])
    );
  end

  // Lanes past N_ELEM on the last partial beat carry no element.
  always_comb begin
    w_live = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_live[i] = ((32'(r_beat) * 32'(LANES)) + i) < 32'(N_ELEM);
    end
  end

  // Sum of all lane metrics for the beat sitting in S2.
  always_comb begin
    w_tree = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_tree = w_tree + ACC_W'(r_s2_metric[i]);
    end
  end

  // Pipeline valid bits: one per stage, advancing every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Pipeline data: S1 diff (masked lanes zeroed), S2 lane metric, S3 lane sum.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (w_accept) begin
        r_s1_diff[i] <= w_live[i] ? w_diff[i] : '0;
      end
      r_s2_metric[i] <= w_metric[i];
    end
    r_s3_sum <= w_tree;
  end

  // Accumulator: cleared when a vector starts, adds each lane sum leaving S3.
  always_ff @(posedge clk) begin
    if (rst || w_start_take) begin
      r_acc <= '0;
    end else if (r_s3_valid) begin
      r_acc <= r_acc + r_s3_sum;
    end
  end

  // Control FSM with registered handshake outputs, beat counter and tag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_dist  <= '0;
      r_out_type  <= '0;
      r_busy      <= 1'b0;
      r_beat      <= '0;
      r_mode      <= MODE_SQ;
      r_type      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_take) begin
            r_mode     <= mode;
            r_beat     <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (r_beat == '0) begin
              r_type <= in_type;
            end
            if (r_beat == BCW'(BEATS - 1)) begin
              r_in_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end
            r_beat <= r_beat + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_pipe_empty) begin
            r_out_valid <= 1'b1;
            r_out_dist  <= r_acc;
            r_out_type  <= r_type;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_start_take) begin
              r_mode     <= mode;
              r_beat     <= '0;
              r_in_ready <= 1'b1;
              r_state    <= ST_RUN;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_dist  = r_out_dist;
  assign out_type  = r_out_type;
  assign busy      = r_busy;

endmodule

// File: tb/tb_knn_distance_engine.sv
// Bench for knn_distance_engine: two instances (N_ELEM=8 and N_ELEM=6, both
// LANES=4 so both take 2 beats) share every input; results are compared to a
// plain-arithmetic distance over the first N_ELEM elements of the vectors.
module tb_knn_distance_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_type;
  logic        out_ready;

  logic        in_ready8, out_valid8, busy8;
  logic [19:0] out_dist8;
  logic [3:0]  out_type8;
  logic        in_ready6, out_valid6, busy6;
  logic [19:0] out_dist6;
  logic [3:0]  out_type6;

  int tests_run;
  int tests_failed;
  int a_vec [8];
  int b_vec [8];

  knn_distance_engine #(.W(8), .N_ELEM(8), .LANES(4), .TYPE_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b), .in_type(in_type),
    .out_valid(out_valid8), .out_ready(out_ready), .out_dist(out_dist8), .out_type(out_type8),
    .busy(busy8)
  );

  knn_distance_engine #(.W(8), .N_ELEM(6), .LANES(4), .TYPE_W(4)) dut6 (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready6), .in_a(in_a), .in_b(in_b), .in_type(in_type),
    .out_valid(out_valid6), .out_ready(out_ready), .out_dist(out_dist6), .out_type(out_type6),
    .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: distance over the first n elements, straight from the definition.
  function automatic int ref_dist(input int n, input bit m);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      int d;
      d = a_vec[i] - b_vec[i];
      s += m ? ((d < 0) ? -d : d) : d * d;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_const(input int av, input int bv);
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = av;
      b_vec[i] = bv;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = int'($urandom_range(0, 255)) - 128;
      b_vec[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic pack(input int beat);
    for (int i = 0; i < 4; i++) begin
      in_a[i*8 +: 8] = 8'(a_vec[beat*4+i]);
      in_b[i*8 +: 8] = 8'(b_vec[beat*4+i]);
    end
  endtask

  // Optionally starts a vector, streams its two beats (gap_mask bit c holds
  // in_valid low in cycle c), then waits for out_valid. lat = cycles from the
  // start edge to out_valid (-1 on timeout); rdy_late counts in_ready highs
  // seen after the last beat was taken.
  task automatic do_vector(input bit m, input logic [3:0] t, input bit do_start,
                           input int gap_mask, input bit pulse_start,
                           output int lat, output int rdy_late);
    int beat;
    int cyc;
    bit acc;
    lat = -1;
    rdy_late = 0;
    beat = 0;
    cyc = 0;
    if (do_start) begin
      start = 1'b1;
      mode = m;
      tick();
      start = 1'b0;
      mode = 1'($urandom_range(0, 1));
    end
    while (beat < 2 && cyc < 30) begin
      in_valid = ((gap_mask >> cyc) & 1) == 0;
      in_type = (beat == 0) ? t : ~t;
      if (in_valid) pack(beat);
      else begin
        in_a = $urandom;
        in_b = $urandom;
      end
      start = pulse_start && !in_valid;
      acc = in_valid && in_ready8;
      tick();
      cyc++;
      if (acc) beat++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_type = ~t;
    while (!out_valid8 && cyc < 60) begin
      if (in_ready8) rdy_late++;
      tick();
      cyc++;
    end
    if (out_valid8) lat = cyc;
  endtask

  task automatic accept_out(input bit st, input bit m);
    out_ready = 1'b1;
    start = st;
    mode = m;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_type = '0; out_ready = 1'b0;
    repeat (3) tick();
    tests_run++; if (in_ready8 !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready8); end
    tests_run++; if (out_valid8 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid8); end
    tests_run++; if (out_dist8 !== 20'd0) begin tests_failed++; $display("FAIL reset_out_dist got %0d exp 0", out_dist8); end
    tests_run++; if (out_type8 !== 4'd0) begin tests_failed++; $display("FAIL reset_out_type got %0d exp 0", out_type8); end
    tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy8); end
    tests_run++; if ({in_ready6, out_valid6, busy6} !== 3'b000) begin tests_failed++; $display("FAIL reset_dut6 got %b exp 000", {in_ready6, out_valid6, busy6}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, rl, e8, e6;
    load_const(3, 1);
    e8 = ref_dist(8, 1'b0);
    e6 = ref_dist(6, 1'b0);
    do_vector(1'b0, 4'd5, 1'b1, 0, 1'b0, lat, rl);
    tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL basic_latency got %0d exp 6", lat); end
    tests_run++; if (out_dist8 !== 20'(e8)) begin tests_failed++; $display("FAIL basic_dist8 got %0d exp %0d", out_dist8, e8); end
    tests_run++; if (out_dist6 !== 20'(e6)) begin tests_failed++; $display("FAIL basic_dist6 got %0d exp %0d", out_dist6, e6); end
    tests_run++; if (out_type8 !== 4'd5) begin tests_failed++; $display("FAIL basic_type got %0d exp 5", out_type8); end
    tests_run++; if (out_valid6 !== 1'b1) begin tests_failed++; $display("FAIL basic_valid6 got %b exp 1", out_valid6); end
    tests_run++; if (rl !== 0) begin tests_failed++; $display("FAIL basic_ready_after_last got %0d exp 0", rl); end
    tests_run++; if (busy8 !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got %b exp 1", busy8); end
    accept_out(1'b0, 1'b0);
    tests_run++; if (out_valid8 !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop got %b exp 0", out_valid8); end
    tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_drop got %b exp 0", busy8); end
  endtask

  task automatic test_extremes();
    int lat, rl, e8, e6;
    for (int k = 0; k < 2; k++) begin
      bit m;
      m = (k == 0);
      load_const(-128, 127);
      e8 = ref_dist(8, m);
      e6 = ref_dist(6, m);
      do_vector(m, 4'($urandom_range(0, 15)), 1'b1, 0, 1'b0, lat, rl);
      tests_run++; if (out_dist8 !== 20'(e8)) begin tests_failed++; $display("FAIL extreme_dist8 mode %0d got %0d exp %0d", m, out_dist8, e8); end
      tests_run++; if (out_dist6 !== 20'(e6)) begin tests_failed++; $display("FAIL extreme_dist6 mode %0d got %0d exp %0d", m, out_dist6, e6); end
      accept_out(1'b0, 1'b0);
    end
  endtask

  task automatic test_partial();
    int lat, rl, e8, e6;
    load_const(2, 0);
    for (int i = 6; i < 8; i++) begin
      a_vec[i] = int'($urandom_range(1, 127));
      b_vec[i] = -int'($urandom_range(1, 100));
    end
    e8 = ref_dist(8, 1'b0);
    e6 = ref_dist(6, 1'b0);
    do_vector(1'b0, 4'd9, 1'b1, 0, 1'b0, lat, rl);
    tests_run++; if (out_dist6 !== 20'(e6)) begin tests_failed++; $display("FAIL partial_dist6 got %0d exp %0d", out_dist6, e6); end
    tests_run++; if (out_dist8 !== 20'(e8)) begin tests_failed++; $display("FAIL partial_dist8 got %0d exp %0d", out_dist8, e8); end
    tests_run++; if (out_type6 !== 4'd9) begin tests_failed++; $display("FAIL partial_type6 got %0d exp 9", out_type6); end
    accept_out(1'b0, 1'b0);
  endtask

  task automatic test_stall();
    int lat, rl, e8;
    bit m;
    logic [3:0] t;
    load_random();
    m = 1'($urandom_range(0, 1));
    t = 4'($urandom_range(0, 15));
    e8 = ref_dist(8, m);
    do_vector(m, t, 1'b1, 32'b010, 1'b1, lat, rl);
    tests_run++; if (lat !== 7) begin tests_failed++; $display("FAIL stall_latency got %0d exp 7", lat); end
    tests_run++; if (rl !== 0) begin tests_failed++; $display("FAIL stall_ready_drain got %0d exp 0", rl); end
    for (int j = 0; j < 5; j++) begin
      start = j[0];
      tick();
      tests_run++; if (out_valid8 !== 1'b1) begin tests_failed++; $display("FAIL stall_hold_valid cyc %0d got %b exp 1", j, out_valid8); end
      tests_run++; if (out_dist8 !== 20'(e8)) begin tests_failed++; $display("FAIL stall_hold_dist cyc %0d got %0d exp %0d", j, out_dist8, e8); end
      tests_run++; if (out_type8 !== t) begin tests_failed++; $display("FAIL stall_hold_type cyc %0d got %0d exp %0d", j, out_type8, t); end
      tests_run++; if (in_ready8 !== 1'b0) begin tests_failed++; $display("FAIL stall_hold_ready cyc %0d got %b exp 0", j, in_ready8); end
    end
    start = 1'b0;
    accept_out(1'b0, 1'b0);
    tests_run++; if (busy8 !== 1'b0) begin tests_failed++; $display("FAIL stall_busy_end got %b exp 0", busy8); end
    tick();
    tests_run++; if (in_ready8 !== 1'b0) begin tests_failed++; $display("FAIL stall_idle_ready got %b exp 0", in_ready8); end
  endtask

  task automatic test_rst_abort();
    int lat, rl, e8, e6;
    bit m;
    logic [3:0] t;
    load_random();
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_type = 4'd3;
    pack(0);
    tick();
    pack(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tests_run++; if ({in_ready8, out_valid8, busy8} !== 3'b000) begin tests_failed++; $display("FAIL abort_ctrl got %b exp 000", {in_ready8, out_valid8, busy8}); end
    tests_run++; if (out_dist8 !== 20'd0) begin tests_failed++; $display("FAIL abort_dist got %0d exp 0", out_dist8); end
    tests_run++; if (out_type8 !== 4'd0) begin tests_failed++; $display("FAIL abort_type got %0d exp 0", out_type8); end
    repeat (2) tick();
    tests_run++; if (out_valid8 !== 1'b0) begin tests_failed++; $display("FAIL abort_no_result got %b exp 0", out_valid8); end
    load_random();
    m = 1'($urandom_range(0, 1));
    t = 4'($urandom_range(0, 15));
    e8 = ref_dist(8, m);
    e6 = ref_dist(6, m);
    do_vector(m, t, 1'b1, 0, 1'b0, lat, rl);
    tests_run++; if (out_dist8 !== 20'(e8)) begin tests_failed++; $display("FAIL abort_rerun_dist8 got %0d exp %0d", out_dist8, e8); end
    tests_run++; if (out_dist6 !== 20'(e6)) begin tests_failed++; $display("FAIL abort_rerun_dist6 got %0d exp %0d", out_dist6, e6); end
    tests_run++; if (out_type8 !== t) begin tests_failed++; $display("FAIL abort_rerun_type got %0d exp %0d", out_type8, t); end
    accept_out(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat, rl, e8a, e8b, e6b;
    bit m1, m2;
    logic [3:0] t1, t2;
    load_random();
    m1 = 1'($urandom_range(0, 1));
    t1 = 4'($urandom_range(0, 15));
    e8a = ref_dist(8, m1);
    do_vector(m1, t1, 1'b1, 0, 1'b0, lat, rl);
    tests_run++; if (out_dist8 !== 20'(e8a)) begin tests_failed++; $display("FAIL b2b_first_dist got %0d exp %0d", out_dist8, e8a); end
    tests_run++; if (out_type8 !== t1) begin tests_failed++; $display("FAIL b2b_first_type got %0d exp %0d", out_type8, t1); end
    load_random();
    m2 = ~m1;
    t2 = ~t1;
    e8b = ref_dist(8, m2);
    e6b = ref_dist(6, m2);
    accept_out(1'b1, m2);
    tests_run++; if ({busy8, in_ready8, out_valid8} !== 3'b110) begin tests_failed++; $display("FAIL b2b_restart got %b exp 110", {busy8, in_ready8, out_valid8}); end
    do_vector(m2, t2, 1'b0, 0, 1'b0, lat, rl);
    tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL b2b_latency got %0d exp 6", lat); end
    tests_run++; if (out_dist8 !== 20'(e8b)) begin tests_failed++; $display("FAIL b2b_second_dist8 got %0d exp %0d", out_dist8, e8b); end
    tests_run++; if (out_dist6 !== 20'(e6b)) begin tests_failed++; $display("FAIL b2b_second_dist6 got %0d exp %0d", out_dist6, e6b); end
    tests_run++; if (out_type8 !== t2) begin tests_failed++; $display("FAIL b2b_second_type got %0d exp %0d", out_type8, t2); end
    accept_out(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int lat, rl, e8, e6;
    bit m;
    logic [3:0] t;
    for (int n = 0; n < 6; n++) begin
      load_random();
      m = 1'($urandom_range(0, 1));
      t = 4'($urandom_range(0, 15));
      e8 = ref_dist(8, m);
      e6 = ref_dist(6, m);
      do_vector(m, t, 1'b1, int'($urandom_range(0, 7)), 1'b1, lat, rl);
      tests_run++; if (out_dist8 !== 20'(e8)) begin tests_failed++; $display("FAIL rand%0d_dist8 got %0d exp %0d", n, out_dist8, e8); end
      tests_run++; if (out_dist6 !== 20'(e6)) begin tests_failed++; $display("FAIL rand%0d_dist6 got %0d exp %0d", n, out_dist6, e6); end
      tests_run++; if (out_type8 !== t) begin tests_failed++; $display("FAIL rand%0d_type got %0d exp %0d", n, out_type8, t); end
      tests_run++; if (rl !== 0) begin tests_failed++; $display("FAIL rand%0d_ready_drain got %0d exp 0", n, rl); end
      repeat ($urandom_range(0, 3)) tick();
      accept_out(1'b0, 1'b0);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_partial();
    test_stall();
    test_rst_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
